// File: rtl/image_stream_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vt512_img_pkg
// Shared definitions for the VT512 image stream controller: frame state
// encoding, Wishbone register map, CTRL bit positions, STATUS field offsets
// and the frame word-count helper.
// -----------------------------------------------------------------------------
package vt512_img_pkg;

   typedef enum logic [1:0] {
      IMG_IDLE   = 2'd0,
      IMG_STREAM = 2'd1,
      IMG_DRAIN  = 2'd2,
      IMG_DONE   = 2'd3
   } img_state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DATA   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   localparam int ABORT_BIT  = 31;
   localparam int ERRCLR_BIT = 30;

   localparam int STAT_ERR_BIT   = 31;
   localparam int STAT_FULL_BIT  = 30;
   localparam int STAT_EMPTY_BIT = 29;
   localparam int STAT_STATE_LSB = 27;
   localparam int STAT_WORDS_LSB = 0;

   // Words per frame: ceil(side*side/4). The 19-bit product covers 512*512;
   // the quotient is the upper 17 bits, rounded up if any pixel spills over.
   function automatic logic [16:0] calc_total_words(input logic [9:0] side);
      logic [18:0] pixels;
      pixels = {9'd0, side} * {9'd0, side};
      return pixels[18:2] + {16'd0, |pixels[1:0]};
   endfunction

endpackage

// File: rtl/image_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// image_stream_ctrl_if
// Bundles the Wishbone slave bus and the outbound pixel stream.
//   slave  : controller view (receives Wishbone, sources the pixel stream)
//   master : host/CNN view (drives Wishbone, sinks the pixel stream)
// -----------------------------------------------------------------------------
interface image_stream_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  wbs_cyc_i;
   logic                  wbs_stb_i;
   logic                  wbs_we_i;
   logic [1:0]            wbs_adr_i;
   logic [DATA_WIDTH-1:0] wbs_dat_i;
   logic                  wbs_ack_o;
   logic [DATA_WIDTH-1:0] wbs_dat_o;
   logic [DATA_WIDTH-1:0] pix_data_o;
   logic                  pix_valid_o;
   logic                  pix_ready_i;
   logic                  pix_last_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, pix_ready_i,
      output wbs_ack_o, wbs_dat_o, pix_data_o, pix_valid_o, pix_last_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, pix_ready_i,
      input  wbs_ack_o, wbs_dat_o, pix_data_o, pix_valid_o, pix_last_o
   );
endinterface

// File: rtl/image_stream_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// img_sync_fifo
// Single-clock show-ahead FIFO: dout always presents the oldest entry.
//   clk, rst_n   : clock, async active-low reset
//   flush        : empties the FIFO on the next edge (wins over push/pop)
//   push, din    : write port (ignored when full)
//   pop, dout    : read port (ignored when empty)
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module img_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; the consumer masks dout while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/image_stream_ctrl.sv
// -----------------------------------------------------------------------------
// image_stream_ctrl
// Wishbone frame controller for the VT512 image path. Firmware writes a frame
// size to CTRL, streams packed pixel words to DATA, and the words leave on a
// valid/ready stream with end-of-frame marking. STATUS reports progress.
//   wb_clk_i, wb_rst_ni : clock, async active-low reset
//   bus (slave)         : Wishbone slave + outbound pixel stream
//   frame_size_o        : latched side length of the active frame
//   frame_done_o        : one-cycle pulse after the last word handshakes
//   err_o               : sticky error flag
// -----------------------------------------------------------------------------
module image_stream_ctrl
   import vt512_img_pkg::*;
#(
   parameter int DATA_WIDTH          = 32,
   parameter int MAX_IMAGE_SIZE      = 512,
   parameter int MAX_IMAGE_SIZE_LOG2 = 9,
   parameter int FIFO_DEPTH          = 8
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_ni,
   image_stream_ctrl_if.slave           bus,
   output logic [MAX_IMAGE_SIZE_LOG2:0] frame_size_o,
   output logic                         frame_done_o,
   output logic                         err_o
);
   localparam int SW = MAX_IMAGE_SIZE_LOG2 + 1;
   localparam logic [SW-1:0] MAX_SIDE = SW'(MAX_IMAGE_SIZE);

   localparam logic [1:0] S_IDLE   = IMG_IDLE;
   localparam logic [1:0] S_STREAM = IMG_STREAM;
   localparam logic [1:0] S_DRAIN  = IMG_DRAIN;
   localparam logic [1:0] S_DONE   = IMG_DONE;

   logic [1:0]            state_q, state_d;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
   logic [SW-1:0]         size_q, size_d;
   logic [16:0]           total_q, total_d;
   logic [16:0]           words_in_q, words_in_d;
   logic [16:0]           words_out_q, words_out_d;
   logic                  err_q, err_d;

   logic                  fifo_full, fifo_empty, fifo_valid;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  req, data_wr, stall, accept, ctrl_wr, abort;
   logic                  push, pop, last_word, size_ok, clear_only;
   logic [SW-1:0]         new_size;
   logic [31:0]           status_word;

   // Request decode. A DATA write into a full FIFO is held off (no ack) until
   // a pop frees a slot, so a push never meets a full FIFO.
   assign req        = bus.wbs_cyc_i && bus.wbs_stb_i && !ack_q;
   assign data_wr    = req && bus.wbs_we_i && (bus.wbs_adr_i == ADDR_DATA);
   assign stall      = data_wr && (state_q == S_STREAM) && fifo_full;
   assign accept     = req && !stall;
   assign ctrl_wr    = accept && bus.wbs_we_i && (bus.wbs_adr_i == ADDR_CTRL);
   assign abort      = ctrl_wr && bus.wbs_dat_i[ABORT_BIT];
   assign push       = accept && data_wr && (state_q == S_STREAM);
   assign new_size   = bus.wbs_dat_i[SW-1:0];
   assign size_ok    = (new_size != '0) && (new_size <= MAX_SIDE);
   // An error-clear with a zero size field is a pure clear, not a start.
   assign clear_only = bus.wbs_dat_i[ERRCLR_BIT] && (new_size == '0);

   // Abort beats a concurrent handshake: the word is neither popped nor counted.
   assign fifo_valid = !fifo_empty;
   assign pop        = fifo_valid && bus.pix_ready_i && !abort;
   assign last_word  = fifo_valid && ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                       (words_out_q == total_q - 17'd1);

   assign status_word = {err_q, fifo_full, fifo_empty, state_q, 10'b0, words_in_q};

   img_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .flush (abort),
      .push  (push),
      .din   (bus.wbs_dat_i),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Frame sequencing. CTRL effects are applied last so an abort overrides
   // any transition caused by a handshake on the same edge.
   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      total_d     = total_q;
      words_in_d  = words_in_q;
      words_out_d = words_out_q;
      err_d       = err_q;
      ack_d       = accept;
      rdat_d      = '0;

      if (accept && !bus.wbs_we_i && (bus.wbs_adr_i == ADDR_STATUS))
         rdat_d = DATA_WIDTH'(status_word);

      if (state_q == S_DONE) state_d = S_IDLE;

      if (pop) begin
         words_out_d = words_out_q + 17'd1;
         if (last_word) state_d = S_DONE;
      end

      if (push) begin
         words_in_d = words_in_q + 17'd1;
         if (words_in_q + 17'd1 == total_q) state_d = S_DRAIN;
      end else if (accept && data_wr) begin
         err_d = 1'b1;
      end

      if (ctrl_wr) begin
         if (bus.wbs_dat_i[ERRCLR_BIT]) err_d = 1'b0;
         if (abort) begin
            state_d = S_IDLE;
         end else if (!clear_only) begin
            if ((state_q == S_IDLE) && size_ok) begin
               size_d      = new_size;
               total_d     = calc_total_words(new_size);
               words_in_d  = '0;
               words_out_d = '0;
               state_d     = S_STREAM;
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= S_IDLE;
         ack_q       <= 1'b0;
         rdat_q      <= '0;
         size_q      <= '0;
         total_q     <= '0;
         words_in_q  <= '0;
         words_out_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ack_q       <= ack_d;
         rdat_q      <= rdat_d;
         size_q      <= size_d;
         total_q     <= total_d;
         words_in_q  <= words_in_d;
         words_out_q <= words_out_d;
         err_q       <= err_d;
      end
   end

   assign bus.wbs_ack_o   = ack_q;
   assign bus.wbs_dat_o   = rdat_q;
   assign bus.pix_valid_o = fifo_valid;
   assign bus.pix_data_o  = fifo_valid ? fifo_dout : '0;
   assign bus.pix_last_o  = last_word;
   assign frame_size_o    = size_q;
   assign frame_done_o    = (state_q == S_DONE);
   assign err_o           = err_q;
endmodule

// File: tb/tb_image_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_image_stream_ctrl
// Directed + randomized bench for image_stream_ctrl with a word-level model of
// the expected frame contents and STATUS register.
// -----------------------------------------------------------------------------
module tb_image_stream_ctrl;
   logic clk;
   logic rst_n;
   logic [9:0] frame_size;
   logic frame_done;
   logic err;

   int errors = 0;
   int checks = 0;
   int doneCount = 0;
   bit randReady = 0;

   logic [31:0] rxData[$];
   logic        rxLast[$];
   logic [31:0] expQ[$];

   image_stream_ctrl_if #(.DATA_WIDTH(32)) bus ();

   image_stream_ctrl dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .bus          (bus),
      .frame_size_o (frame_size),
      .frame_done_o (frame_done),
      .err_o        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture handshakes and done pulses half a cycle before the edge that acts on them.
   always @(negedge clk) begin
      if (rst_n && bus.pix_valid_o && bus.pix_ready_i) begin
         rxData.push_back(bus.pix_data_o);
         rxLast.push_back(bus.pix_last_o);
      end
      if (rst_n && frame_done) doneCount++;
   end

   // Random back-pressure for the randomized frames.
   always @(posedge clk) begin
      if (randReady) begin
         #1;
         bus.pix_ready_i = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int totalWords(int side);
      return (side * side + 3) / 4;
   endfunction

   function automatic logic [31:0] statusWord(int e, int f, int em, int st, int win);
      return 32'((e << 31) | (f << 30) | (em << 29) | (st << 27) | win);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One Wishbone transfer; waits up to maxWait edges for ack.
   task automatic applyStimulus(input logic [1:0] adr, input logic we, input logic [31:0] wdata,
                                input int maxWait, output logic acked, output logic [31:0] rdata);
      @(posedge clk); #1;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wdata;
      acked = 1'b0;
      rdata = '0;
      for (int i = 0; i < maxWait && !acked; i++) begin
         @(posedge clk); #1;
         if (bus.wbs_ack_o) begin
            acked = 1'b1;
            rdata = bus.wbs_dat_o;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
   endtask

   task automatic wbWrite(input logic [1:0] adr, input logic [31:0] wdata, input string tag);
      logic a;
      logic [31:0] r;
      applyStimulus(adr, 1'b1, wdata, 200, a, r);
      checkOutput({tag, "_ack"}, 32'(a), 32'd1);
   endtask

   task automatic readStatus(input logic [31:0] exp, input string tag);
      logic a;
      logic [31:0] r;
      applyStimulus(2'd2, 1'b0, 32'd0, 20, a, r);
      checkOutput(tag, r, exp);
   endtask

   task automatic waitDone(input int prev, input string tag);
      for (int i = 0; i < 400 && doneCount == prev; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      checkOutput(tag, 32'(doneCount), 32'(prev + 1));
   endtask

   task automatic checkFrame(input string tag);
      checkOutput({tag, "_count"}, 32'(rxData.size()), 32'(expQ.size()));
      for (int i = 0; i < expQ.size() && i < rxData.size(); i++) begin
         checkOutput($sformatf("%s_data%0d", tag, i), rxData[i], expQ[i]);
         checkOutput($sformatf("%s_last%0d", tag, i), 32'(rxLast[i]), 32'(i == expQ.size() - 1));
      end
      rxData.delete();
      rxLast.delete();
      expQ.delete();
   endtask

   initial begin
      logic a;
      logic [31:0] r, w;
      int side, n, prev, expWordsIn;

      rst_n = 1'b0;
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
      bus.wbs_adr_i = 0; bus.wbs_dat_i = 0; bus.pix_ready_i = 0;
      #12;
      checkOutput("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
      checkOutput("rst_dat", bus.wbs_dat_o, 32'd0);
      checkOutput("rst_valid", 32'(bus.pix_valid_o), 32'd0);
      checkOutput("rst_pixdata", bus.pix_data_o, 32'd0);
      checkOutput("rst_last", 32'(bus.pix_last_o), 32'd0);
      checkOutput("rst_size", 32'(frame_size), 32'd0);
      checkOutput("rst_done", 32'(frame_done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      #11 rst_n = 1'b1;

      // Nominal 4x4 frame
      $display("[TB] nominal frame");
      bus.pix_ready_i = 1'b1;
      prev = doneCount;
      wbWrite(2'd0, 32'd4, "nom_ctrl");
      checkOutput("nom_size", 32'(frame_size), 32'd4);
      for (int i = 0; i < 4; i++) begin
         w = 32'h03020100 + 32'(i) * 32'h04040404;
         expQ.push_back(w);
         wbWrite(2'd1, w, "nom_data");
      end
      waitDone(prev, "nom_done_once");
      checkFrame("nom");
      expWordsIn = 4;
      readStatus(statusWord(0, 0, 1, 0, 4), "nom_status");

      // Odd size: 3x3 = 9 pixels -> 3 words, 4th write is an error
      $display("[TB] odd size");
      prev = doneCount;
      wbWrite(2'd0, 32'd3, "odd_ctrl");
      readStatus(statusWord(0, 0, 1, 1, 0), "odd_status_stream");
      for (int i = 0; i < totalWords(3); i++) begin
         w = $urandom;
         expQ.push_back(w);
         wbWrite(2'd1, w, "odd_data");
      end
      waitDone(prev, "odd_done_once");
      checkFrame("odd");
      wbWrite(2'd1, 32'hDEADBEEF, "odd_extra");
      checkOutput("odd_err", 32'(err), 32'd1);
      expWordsIn = 3;
      readStatus(statusWord(1, 0, 1, 0, 3), "odd_status_err");
      wbWrite(2'd0, 32'h4000_0000, "odd_clr");
      checkOutput("odd_err_clr", 32'(err), 32'd0);

      // Back-pressure: 8x8 -> 16 words
      $display("[TB] back-pressure");
      bus.pix_ready_i = 1'b0;
      prev = doneCount;
      wbWrite(2'd0, 32'd8, "bp_ctrl");
      for (int i = 0; i < 8; i++) begin
         w = $urandom;
         expQ.push_back(w);
         wbWrite(2'd1, w, "bp_data");
      end
      readStatus(statusWord(0, 1, 0, 1, 8), "bp_status_full");
      checkOutput("bp_head_stable", bus.pix_data_o, expQ[0]);
      w = $urandom;
      expQ.push_back(w);
      @(posedge clk); #1;
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
      bus.wbs_adr_i = 2'd1; bus.wbs_dat_i = w;
      a = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.wbs_ack_o) a = 1'b1;
      end
      checkOutput("bp_stall_noack", 32'(a), 32'd0);
      checkOutput("bp_head_held", bus.pix_data_o, expQ[0]);
      bus.pix_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.pix_ready_i = 1'b0;
      for (int i = 0; i < 5 && !a; i++) begin
         @(posedge clk); #1;
         if (bus.wbs_ack_o) a = 1'b1;
      end
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
      checkOutput("bp_release_ack", 32'(a), 32'd1);
      bus.pix_ready_i = 1'b1;
      for (int i = 9; i < 16; i++) begin
         w = $urandom;
         expQ.push_back(w);
         wbWrite(2'd1, w, "bp_data2");
      end
      waitDone(prev, "bp_done_once");
      checkFrame("bp");
      expWordsIn = 16;

      // Illegal sizes
      $display("[TB] illegal sizes");
      wbWrite(2'd0, 32'd0, "ill0_ctrl");
      checkOutput("ill0_err", 32'(err), 32'd1);
      readStatus(statusWord(1, 0, 1, 0, expWordsIn), "ill0_status");
      wbWrite(2'd0, 32'h4000_0000, "ill0_clr");
      checkOutput("ill0_err_clr", 32'(err), 32'd0);
      wbWrite(2'd0, 32'd513, "ill513_ctrl");
      checkOutput("ill513_err", 32'(err), 32'd1);
      readStatus(statusWord(1, 0, 1, 0, expWordsIn), "ill513_status");
      wbWrite(2'd0, 32'h4000_0000, "ill513_clr");
      checkOutput("ill513_err_clr", 32'(err), 32'd0);

      // Randomized frames with random back-pressure
      $display("[TB] random frames");
      for (int f = 0; f < 3; f++) begin
         side = $urandom_range(1, 10);
         n = totalWords(side);
         prev = doneCount;
         randReady = 1;
         wbWrite(2'd0, 32'(side), "rnd_ctrl");
         checkOutput("rnd_size", 32'(frame_size), 32'(side));
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            expQ.push_back(w);
            wbWrite(2'd1, w, "rnd_data");
         end
         randReady = 0;
         @(posedge clk); #2;
         bus.pix_ready_i = 1'b1;
         waitDone(prev, "rnd_done_once");
         checkFrame("rnd");
         expWordsIn = n;
         readStatus(statusWord(0, 0, 1, 0, n), "rnd_status");
      end

      // Abort coinciding with a pop handshake
      $display("[TB] abort");
      bus.pix_ready_i = 1'b0;
      prev = doneCount;
      wbWrite(2'd0, 32'd8, "abt_ctrl");
      for (int i = 0; i < 5; i++) wbWrite(2'd1, $urandom, "abt_data");
      @(posedge clk); #1;
      bus.pix_ready_i = 1'b1;
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
      bus.wbs_adr_i = 2'd0; bus.wbs_dat_i = 32'h8000_0000;
      @(posedge clk); #1;
      checkOutput("abt_ack", 32'(bus.wbs_ack_o), 32'd1);
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
      bus.pix_ready_i = 1'b0;
      checkOutput("abt_valid", 32'(bus.pix_valid_o), 32'd0);
      rxData.delete();
      rxLast.delete();
      repeat (4) @(negedge clk);
      checkOutput("abt_no_done", 32'(doneCount), 32'(prev));
      readStatus(statusWord(0, 0, 1, 0, 5), "abt_status");
      bus.pix_ready_i = 1'b1;
      prev = doneCount;
      wbWrite(2'd0, 32'd4, "abt_next_ctrl");
      for (int i = 0; i < 4; i++) begin
         w = $urandom;
         expQ.push_back(w);
         wbWrite(2'd1, w, "abt_next_data");
      end
      waitDone(prev, "abt_next_done");
      checkFrame("abt_next");

      // Asynchronous reset mid-STREAM
      $display("[TB] async reset");
      bus.pix_ready_i = 1'b0;
      wbWrite(2'd0, 32'd4, "ar_ctrl");
      wbWrite(2'd1, $urandom, "ar_data");
      wbWrite(2'd1, $urandom, "ar_data");
      wbWrite(2'd0, 32'd4, "ar_restart");
      checkOutput("ar_err_set", 32'(err), 32'd1);
      checkOutput("ar_valid_pre", 32'(bus.pix_valid_o), 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_valid", 32'(bus.pix_valid_o), 32'd0);
      checkOutput("ar_pixdata", bus.pix_data_o, 32'd0);
      checkOutput("ar_size", 32'(frame_size), 32'd0);
      checkOutput("ar_err", 32'(err), 32'd0);
      checkOutput("ar_ack", 32'(bus.wbs_ack_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      readStatus(statusWord(0, 0, 1, 0, 0), "ar_status");
      checkOutput("ar_done", 32'(frame_done), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
